ysyx_22040365_mc_core: RTL

Parametrised multi-cycle integer core.
- Successor to the single-cycle addi-only datapath.
- Fetches instructions through a valid/ready handshake and steps a FETCH/EXEC/WB state machine.
- Supports ADDI, ADD, SUB, LUI, AUIPC and EBREAK; any other encoding is illegal and stops the core.
- Sits under the simulation top. The harness supplies instructions and reads write-back results and the halt status.

---
 rtl/ysyx_22040365_mc_core_pkg.sv | 50 +++++
 rtl/ysyx_22040365_mc_core_regfile.sv | 35 +++
 rtl/ysyx_22040365_mc_core.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040365_mc_core_pkg.sv
// Shared encodings for the multi-cycle core: opcodes, funct fields, FSM states,
// halt reasons and the decode classification used between decode and the FSM.
package ysyx_22040365_mc_core_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [6:0] F7_ADD     = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [4:0]  REG_A0      = 5'd10;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic {
    HALT_EBREAK  = 1'b0,
    HALT_ILLEGAL = 1'b1
  } halt_code_t;

  typedef enum logic [2:0] {
    ALU_ADDI,
    ALU_ADD,
    ALU_SUB,
    ALU_LUI,
    ALU_AUIPC
  } alu_op_t;

  typedef enum logic [1:0] {
    DEC_WB,
    DEC_EBREAK,
    DEC_ILLEGAL
  } dec_kind_t;

  // Register index exists in a file of nreg entries.
  function automatic logic idx_ok(input logic [4:0] idx, input int nreg);
    return int'(idx) < nreg;
  endfunction

endpackage

// File: rtl/ysyx_22040365_mc_core_regfile.sv
// Two-read, one-write register file with hardwired x0 and synchronous clear.
// Indices beyond NREG read as zero and are never written.
module ysyx_22040365_regfile_2r1w
  import ysyx_22040365_mc_core_pkg::*;
#(
  parameter int NREG = 32,
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0 && idx_ok(waddr, NREG)) begin
      regs[waddr[AW-1:0]] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0 || !idx_ok(raddr1, NREG)) ? '0 : regs[raddr1[AW-1:0]];
  assign rdata2 = (raddr2 == 5'd0 || !idx_ok(raddr2, NREG)) ? '0 : regs[raddr2[AW-1:0]];

endmodule

// File: rtl/ysyx_22040365_mc_core.sv
// Multi-cycle integer core: FETCH/EXEC/WB state machine executing ADDI, ADD,
// SUB, LUI, AUIPC and EBREAK; anything else halts with the illegal code.
module ysyx_22040365_mc_core
  import ysyx_22040365_mc_core_pkg::*;
#(
  parameter int          XLEN     = 64,
  parameter int          NREG     = 32,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] out,
  output logic            out_valid,
  output logic            halt,
  output logic            halt_code
);

  state_t          state;
  logic [31:0]     ir;
  logic [XLEN-1:0] result;
  halt_code_t      halt_reason;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  logic [4:0]      raddr1;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;

  // Once halted, port 1 is repurposed to expose a0 on out.
  assign raddr1 = (state == ST_HALT) ? REG_A0 : rs1;

  ysyx_22040365_regfile_2r1w #(
    .NREG (NREG),
    .XLEN (XLEN)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (raddr1),
    .raddr2 (rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (state == ST_WB),
    .waddr  (rd),
    .wdata  (result)
  );

  dec_kind_t kind;
  alu_op_t   alu_op;

  always_comb begin
    kind   = DEC_ILLEGAL;
    alu_op = ALU_ADDI;
    case (opcode)
      OPC_OP_IMM: begin
        if (f3 == F3_ADDI && idx_ok(rs1, NREG) && idx_ok(rd, NREG)) begin
          kind   = DEC_WB;
          alu_op = ALU_ADDI;
        end
      end
      OPC_OP: begin
        if (f3 == F3_ADD_SUB && (f7 == F7_ADD || f7 == F7_SUB) &&
            idx_ok(rs1, NREG) && idx_ok(rs2, NREG) && idx_ok(rd, NREG)) begin
          kind   = DEC_WB;
          alu_op = (f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
        end
      end
      OPC_LUI: begin
        if (idx_ok(rd, NREG)) begin
          kind   = DEC_WB;
          alu_op = ALU_LUI;
        end
      end
      OPC_AUIPC: begin
        if (idx_ok(rd, NREG)) begin
          kind   = DEC_WB;
          alu_op = ALU_AUIPC;
        end
      end
      OPC_SYSTEM: begin
        if (ir == INST_EBREAK) kind = DEC_EBREAK;
      end
      default: kind = DEC_ILLEGAL;
    endcase
  end

  logic signed [11:0]     imm_i;
  logic signed [31:0]     imm_u;
  logic signed [XLEN-1:0] imm_i_x;
  logic signed [XLEN-1:0] imm_u_x;
  logic signed [XLEN-1:0] src1;
  logic signed [XLEN-1:0] src2;
  logic signed [XLEN-1:0] alu_res;

  assign imm_i   = $signed(ir[31:20]);
  assign imm_u   = $signed({ir[31:12], 12'b0});
  assign imm_i_x = XLEN'(imm_i);
  assign imm_u_x = XLEN'(imm_u);
  assign src1    = $signed(rdata1);
  assign src2    = $signed(rdata2);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADDI:  alu_res = src1 + imm_i_x;
      ALU_ADD:   alu_res = src1 + src2;
      ALU_SUB:   alu_res = src1 - src2;
      ALU_LUI:   alu_res = imm_u_x;
      ALU_AUIPC: alu_res = $signed(pc) + imm_u_x;
      default:   alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC[XLEN-1:0];
      ir          <= '0;
      result      <= '0;
      halt_reason <= HALT_EBREAK;
    end else begin
      case (state)
        ST_FETCH: begin
          if (inst_valid) begin
            ir    <= inst;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (kind)
            DEC_WB: begin
              result <= alu_res;
              state  <= ST_WB;
            end
            DEC_EBREAK: begin
              halt_reason <= HALT_EBREAK;
              state       <= ST_HALT;
            end
            default: begin
              halt_reason <= HALT_ILLEGAL;
              state       <= ST_HALT;
            end
          endcase
        end
        ST_WB: begin
          pc    <= pc + XLEN'(4);
          state <= ST_FETCH;
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  assign inst_ready = (state == ST_FETCH);
  assign out_valid  = (state == ST_WB);
  assign halt       = (state == ST_HALT);
  assign halt_code  = halt_reason;
  assign out        = halt ? rdata1 : result;

endmodule
